// File: rtl/class2_pkg.sv
// Shared definitions for the class-2 popcount datapath.
package class2_pkg;
  localparam int CLASS2_DEFAULT_WIDTH = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;
endpackage

// File: rtl/class2_unary_tx_if.sv
// Count-in / serial-bit-out handshake bundle for class2_unary_tx.
interface class2_unary_tx_if
  import class2_pkg::*;
#(
  parameter int WIDTH = CLASS2_DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic [CW-1:0] in_count;
  logic          in_valid;
  logic          in_ready;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          err;

  modport master (
    input  in_count, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, busy, err
  );

  modport slave (
    output in_count, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/class2_unary_tx.sv
// Serial thermometer transmitter: a count becomes WIDTH bits, ones first.
// CLASS2_UNARY_SAT_EN: clamp overflow counts to WIDTH instead of dropping them.
module class2_unary_tx
  import class2_pkg::*;
#(
  parameter int WIDTH = CLASS2_DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  class2_unary_tx_if.master bus
);
  localparam int            BW    = $clog2(WIDTH);
  localparam logic [CW-1:0] MAXC  = CW'(WIDTH);
  localparam logic [BW-1:0] LASTB = BW'(WIDTH - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_ones, w_ones_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic          r_bit, w_bit_nxt;
  logic          r_last, w_last_nxt;
  logic          r_err, w_err_nxt;
  logic          w_accept, w_fire, w_ovf, w_drop;
  logic [CW-1:0] w_load;

  // Ready during the final beat lets the next frame follow with no idle cycle.
  assign bus.in_ready  = (r_state == ST_IDLE) || (r_last && bus.out_ready);
  assign bus.out_valid = (r_state == ST_SEND);
  assign bus.busy      = (r_state == ST_SEND);
  assign bus.out_bit   = r_bit;
  assign bus.out_last  = r_last;
  assign bus.err       = r_err;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_fire   = (r_state == ST_SEND) && bus.out_ready;
  assign w_ovf    = bus.in_count > MAXC;

`ifdef CLASS2_UNARY_SAT_EN
  assign w_load = w_ovf ? MAXC : bus.in_count;
  assign w_drop = 1'b0;
`else
  assign w_load = bus.in_count;
  assign w_drop = w_ovf;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ones_nxt  = r_ones;
    w_beat_nxt  = r_beat;
    w_bit_nxt   = r_bit;
    w_last_nxt  = r_last;
    w_err_nxt   = 1'b0;
    if (w_accept) begin
      w_err_nxt  = w_ovf;
      w_ones_nxt = w_load;
      w_beat_nxt = '0;
      w_last_nxt = 1'b0;
      if (w_drop) begin
        w_state_nxt = ST_IDLE;
        w_bit_nxt   = 1'b0;
      end else begin
        w_state_nxt = ST_SEND;
        w_bit_nxt   = (w_load != '0);
      end
    end else if (w_fire) begin
      if (r_last) begin
        w_state_nxt = ST_IDLE;
        w_bit_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
      end else begin
        if (r_ones != '0) w_ones_nxt = r_ones - CW'(1);
        w_beat_nxt = r_beat + BW'(1);
        w_bit_nxt  = (w_ones_nxt != '0);
        w_last_nxt = (w_beat_nxt == LASTB);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ones  <= '0;
      r_beat  <= '0;
      r_bit   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ones  <= w_ones_nxt;
      r_beat  <= w_beat_nxt;
      r_bit   <= w_bit_nxt;
      r_last  <= w_last_nxt;
      r_err   <= w_err_nxt;
    end
  end
endmodule

// File: tb/tb_class2_unary_tx.sv
// Directed bench for class2_unary_tx: WIDTH=7 frames, stalls, loopback, reset, WIDTH=6 overflow.
module tb_class2_unary_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  class2_unary_tx_if #(.WIDTH(7)) if7();
  class2_unary_tx_if #(.WIDTH(6)) if6();

  class2_unary_tx #(.WIDTH(7)) u_tx7 (.clk(clk), .rst_n(rst_n), .bus(if7.master));
  class2_unary_tx #(.WIDTH(6)) u_tx6 (.clk(clk), .rst_n(rst_n), .bus(if6.master));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // beat monitors: record every accepted beat, sampled on the falling edge
  bit q7b[$], q7l[$], q6b[$], q6l[$];
  int q7c[$];
  int cyc = 0;
  int n_err6 = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (if7.out_valid && if7.out_ready) begin
      q7b.push_back(if7.out_bit);
      q7l.push_back(if7.out_last);
      q7c.push_back(cyc);
    end
    if (if6.out_valid && if6.out_ready) begin
      q6b.push_back(if6.out_bit);
      q6l.push_back(if6.out_last);
    end
    if (if6.err) n_err6 <= n_err6 + 1;
  end

  function automatic int pack7(input int base, input int n, input bit sel_last);
    int v = 0;
    for (int i = 0; i < n; i++)
      if (sel_last ? q7l[base+i] : q7b[base+i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int pack6(input int n, input bit sel_last);
    int v = 0;
    for (int i = 0; i < n; i++)
      if (sel_last ? q6l[i] : q6b[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    q7b.delete(); q7l.delete(); q7c.delete();
    q6b.delete(); q6l.delete();
  endtask

  // present a count until accepted; returns just after the accepting edge
  task automatic put(input bit w6, input int c, input bit rnd);
    int n = 0;
    bit ok = 1'b0;
    if (w6) begin if6.in_valid = 1'b1; if6.in_count = 3'(c); end
    else    begin if7.in_valid = 1'b1; if7.in_count = 3'(c); end
    do begin
      if (rnd) if7.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ok = w6 ? if6.in_ready : if7.in_ready;
      step();
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("put_timeout", 0, 1);
    if6.in_valid = 1'b0;
    if7.in_valid = 1'b0;
  endtask

  task automatic wait7(input int n);
    int k = 0;
    while (q7b.size() < n && k < 500) begin step(); k++; end
    if (q7b.size() < n) chk("wait7_timeout", q7b.size(), n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int gaps, c, k;
    bit pstall, pbit, plast;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp_c[$];

    if7.in_valid = 1'b0; if7.in_count = '0; if7.out_ready = 1'b1;
    if6.in_valid = 1'b0; if6.in_count = '0; if6.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst7", {if7.in_ready, if7.out_valid, if7.out_bit, if7.out_last, if7.busy, if7.err}, 6'b100000);
    chk("rst6", {if6.in_ready, if6.out_valid, if6.out_bit, if6.out_last, if6.busy, if6.err}, 6'b100000);
    @(posedge clk); #1; rst_n = 1'b1;
    step();

    // back-to-back counts 0, 3, 7
    clr();
    put(0, 0, 0);
    chk("t1_latency", if7.out_valid, 1);
    put(0, 3, 0);
    put(0, 7, 0);
    wait7(21);
    repeat (3) step();
    chk("t1_nbeats", q7b.size(), 21);
    chk("t1_bits", pack7(0, 21, 0), 32'h1FC380);
    chk("t1_last", pack7(0, 21, 1), 32'h102040);
    gaps = 0;
    for (int i = 1; i < q7c.size(); i++) if (q7c[i] != q7c[i-1] + 1) gaps++;
    chk("t1_gaps", gaps, 0);
    chk("t1_idle", {if7.out_valid, if7.busy, if7.in_ready}, 3'b001);

    // count 5 with a 1,0,0,1 ready pattern
    clr();
    put(0, 5, 0);
    pstall = 1'b0; pbit = 1'b0; plast = 1'b0; k = 0;
    while (q7b.size() < 7 && k < 60) begin
      if7.out_ready = pat[k % 4];
      @(negedge clk);
      if (pstall) chk("t2_hold", {if7.out_valid, if7.out_bit, if7.out_last}, {1'b1, pbit, plast});
      pstall = if7.out_valid && !if7.out_ready;
      pbit = if7.out_bit;
      plast = if7.out_last;
      step();
      k++;
    end
    if7.out_ready = 1'b1;
    repeat (2) step();
    chk("t2_nbeats", q7b.size(), 7);
    chk("t2_bits", pack7(0, 7, 0), 32'h1F);
    chk("t2_last", pack7(0, 7, 1), 32'h40);

    // loopback of random counts with random backpressure
    clr();
    for (int f = 0; f < 1000; f++) begin
      c = $urandom_range(0, 7);
      exp_c.push_back(c);
      put(0, c, 1);
    end
    k = 0;
    while (q7b.size() < 7000 && k < 20000) begin
      if7.out_ready = ($urandom_range(0, 3) != 0);
      step();
      k++;
    end
    if7.out_ready = 1'b1;
    repeat (2) step();
    chk("t3_nbeats", q7b.size(), 7000);
    for (int f = 0; f < 1000; f++) begin
      chk($sformatf("t3_count%0d", f), $countones(pack7(f*7, 7, 0)), exp_c[f]);
      chk($sformatf("t3_frame%0d", f), pack7(f*7, 7, 0) | (pack7(f*7, 7, 1) << 8),
          ((1 << exp_c[f]) - 1) | (32'h40 << 8));
    end

    // WIDTH=6 overflow count 7
    clr();
    c = n_err6;
    put(1, 7, 0);
    @(negedge clk);
    chk("t4_err_pulse", if6.err, 1);
    step();
    @(negedge clk);
    chk("t4_err_clear", if6.err, 0);
    repeat (10) step();
`ifdef CLASS2_UNARY_SAT_EN
    chk("t4_nbeats", q6b.size(), 6);
    chk("t4_bits", pack6(6, 0), 32'h3F);
    chk("t4_last", pack6(6, 1), 32'h20);
`else
    chk("t4_nbeats", q6b.size(), 0);
`endif
    chk("t4_err_count", n_err6 - c, 1);
    chk("t4_idle", {if6.out_valid, if6.in_ready}, 2'b01);
    clr();
    put(1, 2, 0);
    repeat (10) step();
    chk("t4b_nbeats", q6b.size(), 6);
    chk("t4b_bits", pack6(6, 0), 32'h03);
    chk("t4b_last", pack6(6, 1), 32'h20);

    // reset on the third beat of a count-4 frame
    clr();
    put(0, 4, 0);
    k = 0;
    while (q7b.size() < 3 && k < 20) begin @(negedge clk); #1; k++; end
    chk("t5_pre_bit", {if7.out_valid, if7.out_bit}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("t5_rst", {if7.in_ready, if7.out_valid, if7.out_bit, if7.out_last, if7.busy, if7.err}, 6'b100000);
    if7.in_valid = 1'b1; if7.in_count = 3'd5;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_rst_hold", {if7.out_valid, if7.busy}, 2'b00);
    if7.in_valid = 1'b0;
    clr();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) step();
    chk("t5_noresume", q7b.size(), 0);
    put(0, 1, 0);
    wait7(7);
    repeat (2) step();
    chk("t5_nbeats", q7b.size(), 7);
    chk("t5_bits", pack7(0, 7, 0), 32'h01);
    chk("t5_last", pack7(0, 7, 1), 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
